// File: rtl/seq_signed_mult.sv
// seq_signed_mult: iterative shift-add signed/unsigned multiplier with start/busy/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_signed_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, prod_q, prod_d, acc_sum;
  logic [WIDTH-1:0] mplier_q, mplier_d, mag0, mag1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, accept, last;
  always_comb begin
    mag0 = (signed_mode && in0[WIDTH-1]) ? ~in0 + WIDTH'(1) : in0;
    mag1 = (signed_mode && in1[WIDTH-1]) ? ~in1 + WIDTH'(1) : in1;
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SEQ_MULT_EARLY_TERM_EN
    last = ((mplier_q >> 1) == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
    last = cnt_q == CNT_W'(WIDTH - 1);
`endif
    accept = (state_q != RUN) && start;
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    prod_d = prod_q;
    if (accept) begin
      state_d = RUN;
      mcand_d = {{WIDTH{1'b0}}, mag0};
      mplier_d = mag1;
      neg_d = signed_mode & (in0[WIDTH-1] ^ in1[WIDTH-1]);
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      acc_d = acc_sum;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
      state_d = last ? DONE : RUN;
      prod_d = last ? (neg_q ? ~acc_sum + 1'b1 : acc_sum) : prod_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      prod_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      prod_q <= prod_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign prod = prod_q;
endmodule

// File: tb/tb_seq_signed_mult.sv
// tb_seq_signed_mult: vector table, handshake corner cases and random ops on 16- and 8-bit instances.
module tb_seq_signed_mult;
  logic clk = 0, rst = 1;
  logic start16 = 0, sm16 = 0, busy16, done16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;
  logic start8 = 0, sm8 = 0, busy8, done8;
  logic [7:0] a8 = 0, b8 = 0;
  logic [15:0] p8;
  int cmp = 0, err = 0;
  seq_signed_mult #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .in0(a16), .in1(b16), .busy(busy16), .done(done16), .prod(p16));
  seq_signed_mult #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .in0(a8), .in1(b8), .busy(busy8), .done(done8), .prod(p8));
  always #5 clk = ~clk;
  typedef struct { int w; logic sm; logic [15:0] a, b; logic [31:0] exp; string name; } vec_t;
  task automatic check(input string name, input longint act, input longint exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic longint ext(input int w, input logic sm, input logic [15:0] x);
    if (w == 8) return sm ? longint'($signed(x[7:0])) : longint'(x[7:0]);
    return sm ? longint'($signed(x)) : longint'(x);
  endfunction
  function automatic logic [31:0] ref_prod(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = ext(w, sm, a) * ext(w, sm, b);
    return (w == 8) ? 32'(p & 64'hFFFF) : 32'(p & 64'hFFFF_FFFF);
  endfunction
  function automatic int exp_lat(input int w, input logic sm, input logic [15:0] b);
    longint v;
    int hb;
    v = ext(w, sm, b);
    if (v < 0) v = -v;
    hb = 0;
    for (int i = 0; i < w; i++) if (v[i]) hb = i + 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    return (hb == 0) ? 1 : hb;
`else
    return w;
`endif
  endfunction
  task automatic drive(input int w, input logic s, input logic sm, input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin start8 = s; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
    else begin start16 = s; sm16 = sm; a16 = a; b16 = b; end
  endtask
  function automatic logic dn(input int w); return (w == 8) ? done8 : done16; endfunction
  function automatic logic bz(input int w); return (w == 8) ? busy8 : busy16; endfunction
  function automatic logic [31:0] pr(input int w); return (w == 8) ? {16'h0, p8} : p16; endfunction
  task automatic op(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp, input string name);
    int n = 0, busy_low = 0;
    logic seen = 0;
    @(negedge clk);
    drive(w, 1'b1, sm, a, b);
    @(posedge clk);
    #1 drive(w, 1'b0, ~sm, 16'($urandom), 16'($urandom));
    while (n < 40 && !seen) begin
      if (!bz(w)) busy_low++;
      @(posedge clk);
      #1 n++;
      seen = dn(w);
    end
    check({name, "_busy_run"}, busy_low, 0);
    check({name, "_latency"}, seen ? n : -1, exp_lat(w, sm, b));
    check({name, "_prod"}, pr(w), exp);
    check({name, "_busy_done"}, bz(w), 0);
    @(posedge clk);
    #1 check({name, "_done_pulse"}, dn(w), 0);
    check({name, "_prod_hold"}, pr(w), exp);
  endtask
  vec_t vecs[$];
  initial begin
    int n;
    logic seen;
    vecs = '{
      '{16, 1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1, "neg3x5"},
      '{16, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, "minxmin"},
      '{16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "umax"},
      '{16, 1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "smax"},
      '{16, 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, "m1xm1"},
      '{16, 1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF, "m1x1"},
      '{16, 1'b0, 16'h1234, 16'h0010, 32'h0001_2340, "shift"},
      '{16, 1'b0, 16'd1000, 16'h0001, 32'd1000, "k1000x1"},
      '{16, 1'b1, 16'hFFF9, 16'h0000, 32'h0, "m7x0"},
      '{8, 1'b1, 16'h0080, 16'h007F, 32'h0000_C080, "w8_signed"},
      '{8, 1'b0, 16'h0080, 16'h007F, 32'h0000_3F80, "w8_unsigned"}
    };
    #12;
    check("rst_busy16", busy16, 0);
    check("rst_done16", done16, 0);
    check("rst_prod16", p16, 0);
    check("rst_prod8", p8, 0);
    @(negedge clk) rst = 0;
    foreach (vecs[i]) op(vecs[i].w, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    // start held through RUN is ignored; still high in DONE it launches the next op
    @(negedge clk) drive(16, 1'b1, 1'b0, 16'd2, 16'd3);
    @(posedge clk);
    #1 drive(16, 1'b1, 1'b0, 16'd5, 16'd7);
    n = 0; seen = 0;
    while (n < 40 && !seen) begin @(posedge clk); #1 n++; seen = done16; end
    check("b2b_first_latency", seen ? n : -1, exp_lat(16, 1'b0, 16'd3));
    check("b2b_first_prod", p16, 6);
    @(posedge clk);
    #1 drive(16, 1'b0, 1'b0, 16'd0, 16'd0);
    check("b2b_accept_busy", busy16, 1);
    n = 1; seen = 0;
    while (n < 40 && !seen) begin @(posedge clk); #1 n++; seen = done16; end
    check("b2b_second_latency", seen ? n : -1, 1 + exp_lat(16, 1'b0, 16'd7));
    check("b2b_second_prod", p16, 35);
    // asynchronous reset mid-run discards the operation
    @(negedge clk) drive(16, 1'b1, 1'b0, 16'h00FF, 16'h8000);
    @(posedge clk);
    #1 drive(16, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (7) @(posedge clk);
    #2 rst = 1;
    #1 check("arst_busy", busy16, 0);
    check("arst_done", done16, 0);
    check("arst_prod", p16, 0);
    @(negedge clk) rst = 0;
    seen = 0;
    repeat (20) begin @(posedge clk); #1 seen |= done16; end
    check("arst_no_done", seen, 0);
    op(16, 1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1, "after_rst");
    for (int i = 0; i < 30; i++) begin
      logic sm = 1'($urandom);
      logic [15:0] a = 16'($urandom), b = (i % 5 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      op(16, sm, a, b, ref_prod(16, sm, a, b), $sformatf("rnd16_%0d", i));
    end
    for (int i = 0; i < 20; i++) begin
      logic sm = 1'($urandom);
      logic [15:0] a = 16'($urandom_range(0, 255)), b = 16'($urandom_range(0, 255));
      op(8, sm, a, b, ref_prod(8, sm, a, b), $sformatf("rnd8_%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
